// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers for the interrupt logic.
//
// INT_LINES / INT_IDX_W size the interrupt request vectors and their binary
// line index. priority_isolate() and onehot_to_idx() are the pure-function
// forms of the reduction done in max_bit_sel, kept here so the control unit
// can reuse them in its own combinational decode.
package cpu_pkg;

    localparam int unsigned INT_LINES = 8;
    localparam int unsigned INT_IDX_W = 3;

    typedef logic [INT_LINES-1:0] int_vec_t;
    typedef logic [INT_IDX_W-1:0] int_idx_t;

    // Keep only the most-significant set bit. The walk runs from the MSB
    // down, carrying an "already seen a higher bit" term, so the result
    // stays a plain AND/OR network and X bits in req propagate unmasked.
    function automatic int_vec_t priority_isolate(input int_vec_t req);
        int_vec_t res;
        logic     seen;
        res  = '0;
        seen = 1'b0;
        for (int i = INT_LINES - 1; i >= 0; i--) begin
            res[i] = req[i] & ~seen;
            seen   = seen | req[i];
        end
        return res;
    endfunction

    // Binary position of the set bit of a one-hot vector; 0 for all-zeros.
    // Built as an OR of masked constants rather than a priority if-chain.
    function automatic int_idx_t onehot_to_idx(input int_vec_t onehot);
        int_idx_t idx;
        idx = '0;
        for (int i = 0; i < INT_LINES; i++) begin
            idx = idx | ({INT_IDX_W{onehot[i]}} & INT_IDX_W'(i));
        end
        return idx;
    endfunction

endpackage

// File: rtl/max_bit_sel_if.sv
// Signal bundle for one max_bit_sel instance.
//
//   req       request vector, bit WIDTH-1 has highest priority
//   onehot    combinational: only the highest set bit of req
//   onehot_q  registered copy of onehot
//   idx_q     registered binary index of the highest set bit (0 if none)
//   any_q     registered flag, req was nonzero at the last edge
//
// master: the requester / consumer (drives req, reads results).
// slave:  the selector itself.
interface max_bit_sel_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = INT_LINES,
    parameter int unsigned IDX_W = INT_IDX_W
);

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] onehot_q;
    logic [IDX_W-1:0] idx_q;
    logic             any_q;

    modport master (
        output req,
        input  onehot,
        input  onehot_q,
        input  idx_q,
        input  any_q
    );

    modport slave (
        input  req,
        output onehot,
        output onehot_q,
        output idx_q,
        output any_q
    );

endinterface

// File: rtl/max_bit_sel.sv
// Most-significant-bit selector for the interrupt controller.
//
// Reduces a request vector to a one-hot vector that holds only its highest
// set bit. Because the one-hot keeps the numeric weight of that bit, two
// results can be compared as unsigned values to decide pre-emption
// (pending vs. in-service).
//
// Ports:
//   clk    system clock, registered outputs update on its rising edge
//   reset  asynchronous, active-low reset of the registered outputs
//   bus    max_bit_sel_if.slave: req in; onehot (combinational),
//          onehot_q / idx_q / any_q (registered, 1-cycle latency) out
//
// The registers have no enable and load every cycle. onehot does not
// depend on clk or reset.
module max_bit_sel
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = INT_LINES,
    parameter int unsigned IDX_W = INT_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    max_bit_sel_if.slave       bus
);

    // The index output must be able to name every request line.
    if ((2 ** IDX_W) < WIDTH) begin : g_idx_w_check
        $error("max_bit_sel: IDX_W too small for WIDTH");
    end

    logic [WIDTH-1:0] onehot_d;
    logic [IDX_W-1:0] idx_d;
    logic             any_d;

    logic [WIDTH-1:0] onehot_q;
    logic [IDX_W-1:0] idx_q;
    logic             any_q;

    // Priority isolate, MSB down. 'seen' is the OR of all higher req bits,
    // so onehot_d[i] = req[i] & ~|req[WIDTH-1:i+1].
    always_comb begin
        logic seen;
        onehot_d = '0;
        seen     = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            onehot_d[i] = bus.req[i] & ~seen;
            seen        = seen | bus.req[i];
        end
    end

    // Encode the one-hot into a binary index. OR of masked constants keeps
    // this free of priority logic; the input is already one-hot.
    always_comb begin
        idx_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx_d = idx_d | ({IDX_W{onehot_d[i]}} & IDX_W'(i));
        end
    end

    assign any_d = |bus.req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            onehot_q <= '0;
            idx_q    <= '0;
            any_q    <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
            any_q    <= any_d;
        end
    end

    assign bus.onehot   = onehot_d;
    assign bus.onehot_q = onehot_q;
    assign bus.idx_q    = idx_q;
    assign bus.any_q    = any_q;

endmodule

// File: tb/tb_max_bit_sel.sv
// Directed bench for max_bit_sel: two instances (A, B) as used by the
// control unit for pending and in-service vectors.
module tb_max_bit_sel;

    logic clk;
    logic reset;

    int unsigned n_tests;
    int unsigned n_fail;

    max_bit_sel_if #(.WIDTH(8), .IDX_W(3)) if_a ();
    max_bit_sel_if #(.WIDTH(8), .IDX_W(3)) if_b ();

    max_bit_sel #(.WIDTH(8), .IDX_W(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    max_bit_sel #(.WIDTH(8), .IDX_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ascending scan, the last set bit seen wins.
    function automatic logic [7:0] ref_onehot(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) if (v[b]) r = 8'(1 << b);
        return r;
    endfunction

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) if (v[b]) r = 3'(b);
        return r;
    endfunction

    initial begin
        logic [7:0] v;
        n_tests = 0;
        n_fail  = 0;

        // Reset held low with a request present.
        reset     = 1'b0;
        if_a.req  = 8'hA5;
        if_b.req  = 8'h00;
        #1;
        check_eq("rst_onehot", 32'(if_a.onehot), 32'h80);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_onehot_q", 32'(if_a.onehot_q), 32'h00);
            check_eq("rst_idx_q",    32'(if_a.idx_q),    32'h0);
            check_eq("rst_any_q",    32'(if_a.any_q),    32'h0);
        end

        // Release, one request pattern.
        @(negedge clk);
        reset    = 1'b1;
        if_a.req = 8'b0001_0110;
        #1;
        check_eq("p1_onehot", 32'(if_a.onehot), 32'h10);
        @(posedge clk);
        #1;
        check_eq("p1_onehot_q", 32'(if_a.onehot_q), 32'h10);
        check_eq("p1_idx_q",    32'(if_a.idx_q),    32'd4);
        check_eq("p1_any_q",    32'(if_a.any_q),    32'd1);

        // Zero request.
        @(negedge clk);
        if_a.req = 8'h00;
        #1;
        check_eq("z_onehot", 32'(if_a.onehot), 32'h00);
        @(posedge clk);
        #1;
        check_eq("z_onehot_q", 32'(if_a.onehot_q), 32'h00);
        check_eq("z_idx_q",    32'(if_a.idx_q),    32'd0);
        check_eq("z_any_q",    32'(if_a.any_q),    32'd0);

        // Full sweep against the reference model.
        for (int n = 0; n < 256; n++) begin
            v = 8'(n);
            @(negedge clk);
            if_a.req = v;
            #1;
            check_eq("sw_onehot", 32'(if_a.onehot), 32'(ref_onehot(v)));
            check_eq("sw_ones", $countones(if_a.onehot), (v != 0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            check_eq("sw_onehot_q", 32'(if_a.onehot_q), 32'(ref_onehot(v)));
            check_eq("sw_idx_q",    32'(if_a.idx_q),    32'(ref_idx(v)));
            check_eq("sw_any_q",    32'(if_a.any_q),    (v != 0) ? 32'd1 : 32'd0);
        end

        // Priority comparison between the two instances.
        @(negedge clk);
        if_a.req = 8'h0C;
        if_b.req = 8'h09;
        #1;
        check_eq("cmp_a",    32'(if_a.onehot), 32'h08);
        check_eq("cmp_b",    32'(if_b.onehot), 32'h08);
        check_eq("cmp_eq",   32'(if_a.onehot == if_b.onehot), 32'd1);
        if_a.req = 8'h10;
        #1;
        check_eq("cmp_a2",   32'(if_a.onehot), 32'h10);
        check_eq("cmp_gt",   32'(if_a.onehot > if_b.onehot), 32'd1);

        // Asynchronous reset pulse between edges with all requests set.
        @(negedge clk);
        if_a.req = 8'hFF;
        @(posedge clk);
        #1;
        check_eq("ff_onehot_q", 32'(if_a.onehot_q), 32'h80);
        check_eq("ff_idx_q",    32'(if_a.idx_q),    32'd7);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_onehot_q", 32'(if_a.onehot_q), 32'h00);
        check_eq("mid_idx_q",    32'(if_a.idx_q),    32'd0);
        check_eq("mid_any_q",    32'(if_a.any_q),    32'd0);
        check_eq("mid_onehot",   32'(if_a.onehot),   32'h80);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel_hold_q",   32'(if_a.onehot_q), 32'h00);
        @(posedge clk);
        #1;
        check_eq("rel_onehot_q", 32'(if_a.onehot_q), 32'h80);
        check_eq("rel_idx_q",    32'(if_a.idx_q),    32'd7);
        check_eq("rel_any_q",    32'(if_a.any_q),    32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
